register_op_sequencer: RTL and testbench
========================================

// Module: register_op_sequencer
// PURPOSE
//  Upstream driver of register_file: accepts one decoded register/stack op per handshake and
//  sequences it over 1-3 cycles into REGAX/REGBX/REGAOPX/REGBOPX, a DIN source select and a
//  single-port memory request. Implements MOV, INC, DEC, LOAD, STORE, PUSH (pre-dec) and POP (post-inc).
// PARAMETERS
//  WAIT_LIMIT  0   max cycles a memory request waits for MEM_READY; 0 = unlimited
//  PC_REG      15  index of the auto-incrementing PC; INC/DEC/PUSH/POP with RB==PC_REG are rejected
// PORTS
//  CLK        in   1   clock, all state on rising edge
//  RESET      in   1   synchronous, active-high reset
//  OP_VALID   in   1   decoder presents an op
//  OP_READY   out  1   sequencer can accept (high only in IDLE)
//  OP_CODE    in   3   0 NOP,1 MOV,2 INC,3 DEC,4 PUSH,5 POP,6 LOAD,7 STORE
//  OP_RA      in   4   data register (destination for MOV/LOAD/POP, source for STORE/PUSH)
//  OP_RB      in   4   address/stack-pointer register (source for MOV)
//  REGAX      out  4   to register_file port A select
//  REGBX      out  4   to register_file port B select
//  REGAOPX    out  1   1 = load DIN into REGAX this cycle
//  REGBOPX    out  2   [0] inc/dec enable, [1] 1=inc 0=dec, applies to REGBX
//  DIN_SEL    out  1   0 = register_file DOUT_B, 1 = MEM_RDATA onto register_file DIN
//  MEM_RD     out  1   read request, address = DOUT_B
//  MEM_WR     out  1   write request, address = DOUT_B, data = DOUT_A
//  MEM_READY  in   1   memory completes request this cycle (zero-wait allowed)
//  OP_DONE    out  1   one-cycle pulse in final cycle of each accepted op
//  OP_ERR     out  1   one-cycle pulse with OP_DONE when op rejected or timed out
// BEHAVIOUR
//  - States IDLE, EXEC, PRE_DEC, MEM_WR, MEM_RD, POST_INC. Outputs decoded combinationally from state
//    and latched op (code/RA/RB); latched on OP_VALID&&OP_READY in IDLE.
//  - RESET high at an edge: state<=IDLE, latched op<=NOP/0/0, wait counter<=0, regardless of state;
//    an in-flight op is dropped with no OP_DONE. After reset: OP_READY=1, all other outputs 0.
//  - IDLE: all outputs 0 except OP_READY. Accept -> NOP/MOV/INC/DEC/rejected: EXEC; PUSH: PRE_DEC;
//    POP/LOAD: MEM_RD; STORE: MEM_WR.
//  - EXEC (1 cycle, OP_DONE): MOV REGAX=RA,REGBX=RB,REGAOPX=1,DIN_SEL=0; INC REGBX=RB,REGBOPX=11;
//    DEC REGBX=RB,REGBOPX=01; NOP/rejected no register op (rejected also OP_ERR). -> IDLE.
//  - PRE_DEC (1 cycle): REGBX=RB, REGBOPX=01 -> MEM_WR.
//  - MEM_WR: REGAX=RA, REGBX=RB, MEM_WR=1 held until MEM_READY; that cycle OP_DONE -> IDLE.
//  - MEM_RD: REGBX=RB, MEM_RD=1 held; on MEM_READY same cycle REGAX=RA, REGAOPX=1, DIN_SEL=1.
//    LOAD: OP_DONE -> IDLE. POP: -> POST_INC; if RA==RB, POP skips POST_INC (load wins), OP_DONE here.
//  - POST_INC (1 cycle): REGBX=RB, REGBOPX=11, OP_DONE -> IDLE.
//  - Latency accept->OP_DONE: EXEC ops 1; LOAD/STORE 1+w; PUSH/POP 2+w (w = extra wait cycles).
//  - Wait counter: clears on entering MEM_RD/MEM_WR, increments each non-READY cycle; WAIT_LIMIT>0 and
//    count==WAIT_LIMIT without READY -> drop request, OP_DONE+OP_ERR, no REGAOPX, -> IDLE. PUSH's
//    pre-decrement is not undone. Counter width clog2(WAIT_LIMIT+1), min 1.
//  - Never REGAOPX and REGBOPX[0] in same cycle; MEM_RD/MEM_WR mutually exclusive.
//  - Rejected: INC/DEC/PUSH/POP with RB==PC_REG. RA==PC_REG is legal (loads PC).
// STRUCTURE
//  - reg_op_defs.vh: opcode and state localparams, DIN_SEL and REGBOPX encodings, shared with decoder.
//  - One sub-module: mem_wait_timer (clear/count/expired, WAIT_LIMIT parameter). Rest is one FSM.
// TESTING
//  - Reset mid-PUSH (in MEM_WR, MEM_READY low) -> next cycle IDLE, OP_READY=1, MEM_WR=0, no OP_DONE.
//  - MOV RA=3,RB=7 -> one EXEC cycle REGAX=3,REGBX=7,REGAOPX=1,DIN_SEL=0, OP_DONE; back-to-back ops
//    accepted every 2 cycles.
//  - PUSH RA=2,RB=14, MEM_READY after 2 waits -> PRE_DEC REGBOPX=01 REGBX=14; MEM_WR high 3 cycles
//    REGAX=2,REGBX=14; OP_DONE on 3rd; total 4 cycles.
//  - POP RA=5,RB=14 zero-wait -> MEM_RD cycle REGAOPX=1,DIN_SEL=1,REGAX=5; POST_INC REGBOPX=11; then
//    POP RA=14,RB=14 -> no POST_INC, OP_DONE in MEM_RD cycle.
//  - WAIT_LIMIT=4, LOAD with MEM_READY never high -> MEM_RD high 5 cycles, then OP_DONE+OP_ERR,
//    REGAOPX never asserted.
//  - INC RB=15 -> EXEC with REGBOPX=00, OP_DONE+OP_ERR; DEC RB=0 -> REGBOPX=01, no error.

Source files
------------

// File: rtl/register_op_sequencer_pkg.sv
// rtl/register_op_sequencer_pkg.sv - opcode, state and output encodings shared by the sequencer and decoder
//
// Purpose: one place for the opcode values, FSM state codes, DIN source select
//          and REGBOPX inc/dec encodings, plus the PC-protection rule.
// Ports:   none (package)

package register_op_sequencer_pkg;

    // Decoded op codes presented on OP_CODE
    localparam logic [2:0] OPC_NOP   = 3'd0;
    localparam logic [2:0] OPC_MOV   = 3'd1;
    localparam logic [2:0] OPC_INC   = 3'd2;
    localparam logic [2:0] OPC_DEC   = 3'd3;
    localparam logic [2:0] OPC_PUSH  = 3'd4;
    localparam logic [2:0] OPC_POP   = 3'd5;
    localparam logic [2:0] OPC_LOAD  = 3'd6;
    localparam logic [2:0] OPC_STORE = 3'd7;

    // Sequencer states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_EXEC     = 3'd1;
    localparam logic [2:0] ST_PRE_DEC  = 3'd2;
    localparam logic [2:0] ST_MEM_WR   = 3'd3;
    localparam logic [2:0] ST_MEM_RD   = 3'd4;
    localparam logic [2:0] ST_POST_INC = 3'd5;

    // register_file DIN source
    localparam logic DIN_FROM_REG = 1'b0;
    localparam logic DIN_FROM_MEM = 1'b1;

    // REGBOPX: [0] enable, [1] direction (1 = increment)
    localparam logic [1:0] BOP_NONE = 2'b00;
    localparam logic [1:0] BOP_DEC  = 2'b01;
    localparam logic [1:0] BOP_INC  = 2'b11;

    // The PC auto-increments on its own, so any op that would also step it
    // through port B is refused.
    function automatic logic op_rejected(input logic [2:0] code,
                                         input logic [3:0] rb,
                                         input logic [3:0] pc_reg);
        return ((code == OPC_INC) || (code == OPC_DEC) ||
                (code == OPC_PUSH) || (code == OPC_POP)) && (rb == pc_reg);
    endfunction

endpackage

// File: rtl/register_op_sequencer_mem_wait_timer.sv
// rtl/register_op_sequencer_mem_wait_timer.sv - bounded wait counter for memory requests
//
// Purpose: counts cycles a memory request has waited for MEM_READY and flags
//          when the count reaches WAIT_LIMIT (never when WAIT_LIMIT is 0).
// Ports:   clk      in  clock
//          reset    in  synchronous active-high reset
//          clear    in  force count to 0 (held while no request is pending)
//          count_en in  one more non-ready cycle
//          expired  out count has reached WAIT_LIMIT

module register_op_sequencer_mem_wait_timer #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            // With no limit the counter may wrap; it is never compared then.
            count <= count + 1'b1;
        end
    end

    assign expired = (WAIT_LIMIT != 0) && (count == CW'(WAIT_LIMIT));

endmodule

// File: rtl/register_op_sequencer.sv
// rtl/register_op_sequencer.sv - sequences decoded register/stack ops onto register_file and memory
//
// Purpose: accepts one op per handshake and drives register_file selects,
//          inc/dec and load controls, DIN source and a single memory request
//          over 1-3 cycles (plus memory wait cycles).
// Ports:   CLK, RESET (sync, active-high)
//          OP_VALID/OP_READY/OP_CODE/OP_RA/OP_RB  op handshake from decoder
//          REGAX/REGBX/REGAOPX/REGBOPX/DIN_SEL    register_file controls
//          MEM_RD/MEM_WR/MEM_READY                memory request/complete
//          OP_DONE/OP_ERR                         completion pulses

module register_op_sequencer
    import register_op_sequencer_pkg::*;
#(
    parameter int WAIT_LIMIT = 0,
    parameter int PC_REG     = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       OP_VALID,
    output logic       OP_READY,
    input  logic [2:0] OP_CODE,
    input  logic [3:0] OP_RA,
    input  logic [3:0] OP_RB,
    output logic [3:0] REGAX,
    output logic [3:0] REGBX,
    output logic       REGAOPX,
    output logic [1:0] REGBOPX,
    output logic       DIN_SEL,
    output logic       MEM_RD,
    output logic       MEM_WR,
    input  logic       MEM_READY,
    output logic       OP_DONE,
    output logic       OP_ERR
);

    localparam logic [3:0] PC_SEL = 4'(PC_REG);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [2:0] op_code;
    logic [3:0] op_ra;
    logic [3:0] op_rb;
    logic       in_mem;
    logic       wait_expired;

    assign in_mem = (state == ST_MEM_RD) || (state == ST_MEM_WR);

    register_op_sequencer_mem_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (CLK),
        .reset   (RESET),
        .clear   (!in_mem),
        .count_en(in_mem && !MEM_READY),
        .expired (wait_expired)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            op_code <= OPC_NOP;
            op_ra   <= '0;
            op_rb   <= '0;
        end else begin
            state <= state_next;
            if (OP_VALID && OP_READY) begin
                op_code <= OP_CODE;
                op_ra   <= OP_RA;
                op_rb   <= OP_RB;
            end
        end
    end

    always_comb begin
        state_next = state;
        OP_READY   = 1'b0;
        REGAX      = '0;
        REGBX      = '0;
        REGAOPX    = 1'b0;
        REGBOPX    = BOP_NONE;
        DIN_SEL    = DIN_FROM_REG;
        MEM_RD     = 1'b0;
        MEM_WR     = 1'b0;
        OP_DONE    = 1'b0;
        OP_ERR     = 1'b0;

        case (state)
            ST_IDLE: begin
                OP_READY = 1'b1;
                if (OP_VALID) begin
                    // Rejected stack ops take the single-cycle EXEC path to report the error.
                    if (op_rejected(OP_CODE, OP_RB, PC_SEL)) begin
                        state_next = ST_EXEC;
                    end else begin
                        case (OP_CODE)
                            OPC_PUSH:             state_next = ST_PRE_DEC;
                            OPC_POP, OPC_LOAD:    state_next = ST_MEM_RD;
                            OPC_STORE:            state_next = ST_MEM_WR;
                            default:              state_next = ST_EXEC;
                        endcase
                    end
                end
            end

            ST_EXEC: begin
                OP_DONE    = 1'b1;
                state_next = ST_IDLE;
                if (op_rejected(op_code, op_rb, PC_SEL)) begin
                    OP_ERR = 1'b1;
                end else begin
                    case (op_code)
                        OPC_MOV: begin
                            REGAX   = op_ra;
                            REGBX   = op_rb;
                            REGAOPX = 1'b1;
                            DIN_SEL = DIN_FROM_REG;
                        end
                        OPC_INC: begin
                            REGBX   = op_rb;
                            REGBOPX = BOP_INC;
                        end
                        OPC_DEC: begin
                            REGBX   = op_rb;
                            REGBOPX = BOP_DEC;
                        end
                        default: ;
                    endcase
                end
            end

            ST_PRE_DEC: begin
                REGBX      = op_rb;
                REGBOPX    = BOP_DEC;
                state_next = ST_MEM_WR;
            end

            ST_MEM_WR: begin
                REGAX  = op_ra;
                REGBX  = op_rb;
                MEM_WR = 1'b1;
                if (MEM_READY) begin
                    OP_DONE    = 1'b1;
                    state_next = ST_IDLE;
                end else if (wait_expired) begin
                    // A PUSH's pre-decrement already happened and stays.
                    OP_DONE    = 1'b1;
                    OP_ERR     = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            ST_MEM_RD: begin
                REGBX  = op_rb;
                MEM_RD = 1'b1;
                if (MEM_READY) begin
                    REGAX   = op_ra;
                    REGAOPX = 1'b1;
                    DIN_SEL = DIN_FROM_MEM;
                    // POP into its own stack pointer: the loaded value wins, no post-increment.
                    if ((op_code == OPC_POP) && (op_ra != op_rb)) begin
                        state_next = ST_POST_INC;
                    end else begin
                        OP_DONE    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (wait_expired) begin
                    OP_DONE    = 1'b1;
                    OP_ERR     = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            ST_POST_INC: begin
                REGBX      = op_rb;
                REGBOPX    = BOP_INC;
                OP_DONE    = 1'b1;
                state_next = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_register_op_sequencer.sv
// tb/tb_register_op_sequencer.sv - self-checking bench for register_op_sequencer

module tb_register_op_sequencer;

    localparam int LIMIT = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       OP_VALID;
    logic       OP_READY;
    logic [2:0] OP_CODE;
    logic [3:0] OP_RA;
    logic [3:0] OP_RB;
    logic [3:0] REGAX;
    logic [3:0] REGBX;
    logic       REGAOPX;
    logic [1:0] REGBOPX;
    logic       DIN_SEL;
    logic       MEM_RD;
    logic       MEM_WR;
    logic       MEM_READY;
    logic       OP_DONE;
    logic       OP_ERR;

    int total = 0;
    int bad   = 0;

    logic [16:0] obs[$];
    logic [16:0] exp_q[$];
    logic [16:0] accept_vec;
    time         accept_time;

    register_op_sequencer #(.WAIT_LIMIT(LIMIT), .PC_REG(15)) dut (
        .CLK(CLK), .RESET(RESET), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .OP_CODE(OP_CODE), .OP_RA(OP_RA), .OP_RB(OP_RB),
        .REGAX(REGAX), .REGBX(REGBX), .REGAOPX(REGAOPX), .REGBOPX(REGBOPX),
        .DIN_SEL(DIN_SEL), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_READY(MEM_READY),
        .OP_DONE(OP_DONE), .OP_ERR(OP_ERR)
    );

    always #5 CLK = ~CLK;

    // Output vector: {REGAX, REGBX, REGAOPX, REGBOPX, DIN_SEL, MEM_RD, MEM_WR, OP_DONE, OP_ERR, OP_READY}
    function automatic logic [16:0] pk(input logic [3:0] ax, input logic [3:0] bx, input logic aop,
                                       input logic [1:0] bop, input logic din, input logic rd,
                                       input logic wr, input logic done, input logic err,
                                       input logic rdy);
        return {ax, bx, aop, bop, din, rd, wr, done, err, rdy};
    endfunction

    function automatic logic [16:0] cur();
        return {REGAX, REGBX, REGAOPX, REGBOPX, DIN_SEL, MEM_RD, MEM_WR, OP_DONE, OP_ERR, OP_READY};
    endfunction

    // Expected cycle-by-cycle outputs after the accept edge, from the op's phase list:
    // optional pre-decrement, w+1 memory cycles (LIMIT+1 on timeout), optional post-increment.
    task automatic build_expected(input int code, input logic [3:0] ra, input logic [3:0] rb, input int w);
        bit rej, timeout, last;
        int n;
        exp_q.delete();
        rej = (code >= 2 && code <= 5) && (rb == 4'd15);
        if (rej) begin
            exp_q.push_back(pk(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0));
        end else if (code == 0) begin
            exp_q.push_back(pk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0));
        end else if (code == 1) begin
            exp_q.push_back(pk(ra, rb, 1, 2'b00, 0, 0, 0, 1, 0, 0));
        end else if (code == 2) begin
            exp_q.push_back(pk(0, rb, 0, 2'b11, 0, 0, 0, 1, 0, 0));
        end else if (code == 3) begin
            exp_q.push_back(pk(0, rb, 0, 2'b01, 0, 0, 0, 1, 0, 0));
        end else begin
            timeout = (w > LIMIT);
            n = timeout ? LIMIT + 1 : w + 1;
            if (code == 4) exp_q.push_back(pk(0, rb, 0, 2'b01, 0, 0, 0, 0, 0, 0));
            for (int i = 0; i < n; i++) begin
                last = (i == n - 1);
                if (code == 4 || code == 7)
                    exp_q.push_back(pk(ra, rb, 0, 2'b00, 0, 0, 1, last, last && timeout, 0));
                else if (!last || timeout)
                    exp_q.push_back(pk(0, rb, 0, 2'b00, 0, 1, 0, last, last, 0));
                else
                    exp_q.push_back(pk(ra, rb, 1, 2'b00, 1, 1, 0, (code == 6) || (ra == rb), 0, 0));
            end
            if (code == 5 && ra != rb && !timeout)
                exp_q.push_back(pk(0, rb, 0, 2'b11, 0, 0, 0, 1, 0, 0));
        end
    endtask

    // Presents one op (entered just after a rising edge with the DUT idle), plays a memory
    // that answers after w wait cycles, and records outputs each cycle until OP_DONE.
    task automatic run_op(input int code, input logic [3:0] ra, input logic [3:0] rb, input int w);
        int k;
        logic done;
        OP_VALID = 1'b1;
        OP_CODE  = 3'(code);
        OP_RA    = ra;
        OP_RB    = rb;
        MEM_READY = 1'b0;
        @(negedge CLK);
        accept_vec = cur();
        @(posedge CLK);
        accept_time = $time;
        #1;
        OP_VALID = 1'b0;
        OP_CODE  = 3'd0;
        OP_RA    = 4'd0;
        OP_RB    = 4'd0;
        obs.delete();
        k = 0;
        for (int c = 0; c < 20; c++) begin
            if (MEM_RD || MEM_WR) begin
                MEM_READY = (k >= w);
                k++;
            end else begin
                MEM_READY = 1'b0;
            end
            @(negedge CLK);
            obs.push_back(cur());
            done = OP_DONE;
            @(posedge CLK);
            #1;
            if (done === 1'b1) break;
        end
        MEM_READY = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        total++;
        if (cur() !== pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1)) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", cur(), pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1));
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_mov_back_to_back();
        time prev;
        logic [3:0] ra, rb;
        for (int j = 0; j < 3; j++) begin
            ra = (j == 0) ? 4'd3 : 4'($urandom_range(0, 15));
            rb = (j == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            prev = accept_time;
            build_expected(1, ra, rb, 0);
            run_op(1, ra, rb, 0);
            total++;
            if (accept_vec !== pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1)) begin
                bad++;
                $display("FAIL mov_accept got=%h want=%h", accept_vec, pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1));
            end
            total++;
            if (obs.size() !== exp_q.size()) begin
                bad++;
                $display("FAIL mov_len got=%0d want=%0d", obs.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < obs.size()) begin
                total++;
                if (obs[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL mov_cycle%0d got=%h want=%h", i, obs[i], exp_q[i]);
                end
            end
            if (j > 0) begin
                total++;
                if (accept_time - prev !== 20) begin
                    bad++;
                    $display("FAIL mov_spacing got=%0t want=20", accept_time - prev);
                end
            end
        end
    endtask

    task automatic test_push_wait();
        build_expected(4, 4'd2, 4'd14, 2);
        run_op(4, 4'd2, 4'd14, 2);
        total++;
        if (obs.size() !== 4) begin
            bad++;
            $display("FAIL push_latency got=%0d want=4", obs.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            total++;
            if (obs[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL push_cycle%0d got=%h want=%h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_pop();
        build_expected(5, 4'd5, 4'd14, 0);
        run_op(5, 4'd5, 4'd14, 0);
        total++;
        if (obs.size() !== 2) begin
            bad++;
            $display("FAIL pop_latency got=%0d want=2", obs.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            total++;
            if (obs[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL pop_cycle%0d got=%h want=%h", i, obs[i], exp_q[i]);
            end
        end
        build_expected(5, 4'd14, 4'd14, 0);
        run_op(5, 4'd14, 4'd14, 0);
        total++;
        if (obs.size() !== 1) begin
            bad++;
            $display("FAIL pop_self_latency got=%0d want=1", obs.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            total++;
            if (obs[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL pop_self_cycle%0d got=%h want=%h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int rd_cycles, aop_seen;
        build_expected(6, 4'd9, 4'd4, 100);
        run_op(6, 4'd9, 4'd4, 100);
        rd_cycles = 0;
        aop_seen = 0;
        foreach (obs[i]) begin
            rd_cycles += int'(obs[i][4]);
            aop_seen  += int'(obs[i][8]);
        end
        total++;
        if (rd_cycles !== LIMIT + 1) begin
            bad++;
            $display("FAIL timeout_rd_cycles got=%0d want=%0d", rd_cycles, LIMIT + 1);
        end
        total++;
        if (aop_seen !== 0) begin
            bad++;
            $display("FAIL timeout_regaopx got=%0d want=0", aop_seen);
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            total++;
            if (obs[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL timeout_cycle%0d got=%h want=%h", i, obs[i], exp_q[i]);
            end
        end
        // READY arriving exactly at the limit still completes
        build_expected(6, 4'd9, 4'd4, LIMIT);
        run_op(6, 4'd9, 4'd4, LIMIT);
        total++;
        if (obs.size() !== 1 + LIMIT) begin
            bad++;
            $display("FAIL limit_ok_latency got=%0d want=%0d", obs.size(), 1 + LIMIT);
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            total++;
            if (obs[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL limit_ok_cycle%0d got=%h want=%h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reject();
        int codes[4] = '{2, 3, 4, 7};
        logic [3:0] rbs[4] = '{4'd15, 4'd0, 4'd15, 4'd15};
        for (int j = 0; j < 4; j++) begin
            build_expected(codes[j], 4'd1, rbs[j], 0);
            run_op(codes[j], 4'd1, rbs[j], 0);
            total++;
            if (obs.size() !== exp_q.size()) begin
                bad++;
                $display("FAIL reject%0d_len got=%0d want=%0d", j, obs.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < obs.size()) begin
                total++;
                if (obs[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL reject%0d_cycle%0d got=%h want=%h", j, i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_push();
        OP_VALID = 1'b1;
        OP_CODE  = 3'd4;
        OP_RA    = 4'd2;
        OP_RB    = 4'd14;
        MEM_READY = 1'b0;
        @(posedge CLK);
        #1;
        OP_VALID = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        total++;
        if (MEM_WR !== 1'b1) begin
            bad++;
            $display("FAIL midpush_mem_wr got=%b want=1", MEM_WR);
        end
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        total++;
        if (cur() !== pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1)) begin
            bad++;
            $display("FAIL midpush_reset got=%h want=%h", cur(), pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1));
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_random();
        int code, w;
        logic [3:0] ra, rb;
        for (int j = 0; j < 40; j++) begin
            code = $urandom_range(0, 7);
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            if (code == 5 && $urandom_range(0, 3) == 0) ra = rb;
            w = $urandom_range(0, LIMIT + 1);
            build_expected(code, ra, rb, w);
            run_op(code, ra, rb, w);
            total++;
            if (obs.size() !== exp_q.size()) begin
                bad++;
                $display("FAIL rand%0d_len op=%0d ra=%0d rb=%0d w=%0d got=%0d want=%0d",
                         j, code, ra, rb, w, obs.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < obs.size()) begin
                total++;
                if (obs[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rand%0d_cycle%0d op=%0d got=%h want=%h", j, i, code, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        RESET     = 1'b1;
        OP_VALID  = 1'b0;
        OP_CODE   = 3'd0;
        OP_RA     = 4'd0;
        OP_RB     = 4'd0;
        MEM_READY = 1'b0;
        accept_time = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        test_reset();
        test_mov_back_to_back();
        test_push_wait();
        test_pop();
        test_timeout();
        test_reject();
        test_reset_mid_push();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
